// File: rtl/Predef_pkg.sv
// Shared width helpers and typedefs used across the RAM/FIFO codebase.
// Kept free of design state so any block can import it.
package Predef_pkg;

    typedef logic [7:0] byte_t;

    localparam int BYTE_BITS = 8;

    function automatic int bytes_to_bits(input int num_bytes);
        return num_bytes * BYTE_BITS;
    endfunction

    // Address width for a given depth; never returns 0 so a 1-word array still has a port bit.
    function automatic int addr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/simple_dual_port_ram.sv
// Simple dual-port RAM: one byte-masked write port, one read port that is either
// show-ahead (combinational) or registered with read-first behaviour on collisions.
module simple_dual_port_ram
    import Predef_pkg::*;
#(
    parameter  int WIDTH_BYTES = 4,
    parameter  int DEPTH       = 16,
    parameter  bit SHOWAHEAD   = 1'b0,
    localparam int DW          = bytes_to_bits(WIDTH_BYTES),
    localparam int AW          = addr_width(DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [AW-1:0] write_addr_in,
    input  logic          write_in,
    input  logic [DW-1:0] write_data_in,
    input  logic [WIDTH_BYTES-1:0] write_mask_in,
    input  logic [AW-1:0] read_addr_in,
    input  logic          read_in,
    output logic [DW-1:0] read_data_out,
    input  logic          debugen_in
);

    logic [DW-1:0] read_word;
    logic          write_ok;

    assign write_ok = write_in && !reset;

    // One independent byte-wide array per lane, so each mask bit maps to its own write enable.
    generate
        for (genvar gi = 0; gi < WIDTH_BYTES; gi++) begin : g_lane
            byte_t lane_mem [DEPTH];

            always_ff @(posedge clk) begin
                if (write_ok && write_mask_in[gi]) begin
                    lane_mem[write_addr_in] <= write_data_in[gi*BYTE_BITS +: BYTE_BITS];
                end
            end

            assign read_word[gi*BYTE_BITS +: BYTE_BITS] = lane_mem[read_addr_in];
        end
    endgenerate

    generate
        if (SHOWAHEAD) begin : g_showahead
            assign read_data_out = read_word;
        end else begin : g_registered
            logic [DW-1:0] rd_q_reg;

            // read_word is sampled before this edge's write lands, giving read-first.
            always_ff @(posedge clk) begin
                if (reset) begin
                    rd_q_reg <= '0;
                end else if (read_in) begin
                    rd_q_reg <= read_word;
                end
            end

            assign read_data_out = rd_q_reg;
        end
    endgenerate

    // Trace enable has no functional effect; read_in is unused in show-ahead mode.
    logic unused_ok;
    assign unused_ok = ^{debugen_in, read_in};

endmodule

// File: tb/tb_simple_dual_port_ram.sv
// Directed bench for simple_dual_port_ram: a registered and a show-ahead instance
// share all inputs; table-driven cycles plus hand-written multi-cycle sequences.
module tb_simple_dual_port_ram;

    localparam int WB = 4;
    localparam int DEPTH = 16;
    localparam int DW = WB * 8;
    localparam int AW = 4;

    logic          clk;
    logic          reset;
    logic [AW-1:0] write_addr_in;
    logic          write_in;
    logic [DW-1:0] write_data_in;
    logic [WB-1:0] write_mask_in;
    logic [AW-1:0] read_addr_in;
    logic          read_in;
    logic          debugen_in;
    logic [DW-1:0] rdata_reg;
    logic [DW-1:0] rdata_sa;

    int checks = 0;
    int errors = 0;

    simple_dual_port_ram #(.WIDTH_BYTES(WB), .DEPTH(DEPTH), .SHOWAHEAD(1'b0)) dut_reg (
        .clk(clk), .reset(reset),
        .write_addr_in(write_addr_in), .write_in(write_in),
        .write_data_in(write_data_in), .write_mask_in(write_mask_in),
        .read_addr_in(read_addr_in), .read_in(read_in),
        .read_data_out(rdata_reg), .debugen_in(debugen_in)
    );

    simple_dual_port_ram #(.WIDTH_BYTES(WB), .DEPTH(DEPTH), .SHOWAHEAD(1'b1)) dut_sa (
        .clk(clk), .reset(reset),
        .write_addr_in(write_addr_in), .write_in(write_in),
        .write_data_in(write_data_in), .write_mask_in(write_mask_in),
        .read_addr_in(read_addr_in), .read_in(read_in),
        .read_data_out(rdata_sa), .debugen_in(debugen_in)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string         name;
        logic          rst;
        logic          wr;
        logic [AW-1:0] waddr;
        logic [DW-1:0] wdata;
        logic [WB-1:0] wmask;
        logic          rd;
        logic [AW-1:0] raddr;
        logic          chk_reg;
        logic [DW-1:0] exp_reg;
        logic          chk_sa;
        logic [DW-1:0] exp_sa;
    } vec_t;

    localparam int NV = 17;
    vec_t vecs [NV];

    function automatic vec_t mk(input string name, input logic rst, input logic wr,
                                input logic [AW-1:0] waddr, input logic [DW-1:0] wdata,
                                input logic [WB-1:0] wmask, input logic rd,
                                input logic [AW-1:0] raddr, input logic chk_reg,
                                input logic [DW-1:0] exp_reg, input logic chk_sa,
                                input logic [DW-1:0] exp_sa);
        vec_t v;
        v.name = name; v.rst = rst; v.wr = wr; v.waddr = waddr; v.wdata = wdata;
        v.wmask = wmask; v.rd = rd; v.raddr = raddr; v.chk_reg = chk_reg;
        v.exp_reg = exp_reg; v.chk_sa = chk_sa; v.exp_sa = exp_sa;
        return v;
    endfunction

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end else begin
            $display("ok   %s: %h", name, act);
        end
    endtask

    // Drive one cycle's inputs just after the edge, then sample 1 time unit after the next edge.
    task automatic step(input logic rst, input logic wr, input logic [AW-1:0] waddr,
                        input logic [DW-1:0] wdata, input logic [WB-1:0] wmask,
                        input logic rd, input logic [AW-1:0] raddr);
        reset = rst; write_in = wr; write_addr_in = waddr; write_data_in = wdata;
        write_mask_in = wmask; read_in = rd; read_addr_in = raddr;
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; write_in = 1'b0; write_addr_in = '0; write_data_in = '0;
        write_mask_in = '0; read_in = 1'b0; read_addr_in = '0; debugen_in = 1'b0;

        //                 name           rst  wr  wa  wdata         wm    rd  ra  chkR exp_reg      chkS exp_sa
        vecs[0]  = mk("reset_state",  1, 0, 0, 32'h0,        4'h0, 0, 0, 1, 32'h0,        0, 32'h0);
        vecs[1]  = mk("wr3_hold0",    0, 1, 3, 32'hDEADBEEF, 4'hF, 0, 3, 1, 32'h0,        1, 32'hDEADBEEF);
        vecs[2]  = mk("rd3",          0, 0, 0, 32'h0,        4'h0, 1, 3, 1, 32'hDEADBEEF, 1, 32'hDEADBEEF);
        vecs[3]  = mk("hold_rd3",     0, 0, 0, 32'h0,        4'h0, 0, 5, 1, 32'hDEADBEEF, 0, 32'h0);
        vecs[4]  = mk("wr5_full",     0, 1, 5, 32'h11223344, 4'hF, 0, 5, 1, 32'hDEADBEEF, 1, 32'h11223344);
        vecs[5]  = mk("wr5_mask0101", 0, 1, 5, 32'hAABBCCDD, 4'h5, 0, 5, 0, 32'h0,        1, 32'h11BB33DD);
        vecs[6]  = mk("rd5_masked",   0, 0, 0, 32'h0,        4'h0, 1, 5, 1, 32'h11BB33DD, 1, 32'h11BB33DD);
        vecs[7]  = mk("wr5_mask0",    0, 1, 5, 32'hFFFFFFFF, 4'h0, 1, 5, 1, 32'h11BB33DD, 1, 32'h11BB33DD);
        vecs[8]  = mk("wr7_1",        0, 1, 7, 32'h1,        4'hF, 0, 7, 0, 32'h0,        1, 32'h1);
        vecs[9]  = mk("rdw7_oldword", 0, 1, 7, 32'h2,        4'hF, 1, 7, 1, 32'h1,        1, 32'h2);
        vecs[10] = mk("rd7_newword",  0, 0, 0, 32'h0,        4'h0, 1, 7, 1, 32'h2,        1, 32'h2);
        vecs[11] = mk("wr0_cafe",     0, 1, 0, 32'hCAFEF00D, 4'hF, 0, 0, 1, 32'h2,        1, 32'hCAFEF00D);
        vecs[12] = mk("wr1_5_indep",  0, 1, 1, 32'h5,        4'hF, 1, 3, 1, 32'hDEADBEEF, 1, 32'hDEADBEEF);
        vecs[13] = mk("rd3_again",    0, 0, 0, 32'h0,        4'h0, 1, 3, 1, 32'hDEADBEEF, 0, 32'h0);
        vecs[14] = mk("rst_drop_wr",  1, 1, 3, 32'h0,        4'hF, 1, 3, 1, 32'h0,        1, 32'hDEADBEEF);
        vecs[15] = mk("rd3_after_rst",0, 0, 0, 32'h0,        4'h0, 1, 3, 1, 32'hDEADBEEF, 1, 32'hDEADBEEF);
        vecs[16] = mk("rd_ignored_sa",0, 0, 0, 32'h0,        4'h0, 0, 1, 1, 32'hDEADBEEF, 1, 32'h5);

        @(posedge clk);
        #1;
        for (int i = 0; i < NV; i++) begin
            step(vecs[i].rst, vecs[i].wr, vecs[i].waddr, vecs[i].wdata, vecs[i].wmask,
                 vecs[i].rd, vecs[i].raddr);
            if (vecs[i].chk_reg) check({vecs[i].name, "/reg"}, rdata_reg, vecs[i].exp_reg);
            if (vecs[i].chk_sa)  check({vecs[i].name, "/sa"},  rdata_sa,  vecs[i].exp_sa);
        end

        // Show-ahead output must follow the address mid-cycle with no clock edge.
        step(0, 0, 0, 32'h0, 4'h0, 0, 0);
        @(negedge clk);
        read_addr_in = 1;
        #1;
        check("sa_comb_addr1", rdata_sa, 32'h5);
        read_addr_in = 0;
        #1;
        check("sa_comb_addr0", rdata_sa, 32'hCAFEF00D);
        @(posedge clk);
        #1;

        // Fill every word, then read all back-to-back.
        for (int k = 0; k < DEPTH; k++) begin
            step(0, 1, AW'(k), DW'(k), 4'hF, 0, 0);
        end
        for (int k = 0; k < DEPTH; k++) begin
            step(0, 0, 0, 32'h0, 4'h0, 1, AW'(k));
            check($sformatf("fill_rd%0d", k), rdata_reg, DW'(k));
        end
        step(0, 0, 0, 32'h0, 4'h0, 1, 15);
        check("wrap_rd15", rdata_reg, 32'd15);
        step(0, 0, 0, 32'h0, 4'h0, 1, 0);
        check("wrap_rd0", rdata_reg, 32'd0);
        check("wrap_sa0", rdata_sa, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
